// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped, read-only instruction cache with single-burst AXI4 line refill.
// Optional hit/miss counters are compiled in when YSYX_23060025_ICACHE_PERF_EN is defined.
module ysyx_23060025_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_psel,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  output logic                  in_pready,
  output logic [DATA_WIDTH-1:0] in_prdata,
  input  logic                  fencei_i,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast
`ifdef YSYX_23060025_ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hit_cnt,
  output logic [31:0]           perf_miss_cnt
`endif
);

  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int OFF  = OFFW + 2;
  localparam int TAGW = ADDR_WIDTH - OFF - IDXW;
  localparam logic [OFFW-1:0] LAST_BEAT = OFFW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
  logic [OFFW-1:0]         cnt_q, cnt_d;
  logic                    fence_pend_q, fence_pend_d;
  logic                    err_q, err_d;
  logic                    over_q, over_d;
  logic [DATA_WIDTH-1:0]   resp_q, resp_d;
  logic [SETS-1:0]         valid_q, valid_d;

  logic [TAGW-1:0]         tag_q  [SETS];
  logic [DATA_WIDTH-1:0]   data_q [SETS][LINE_WORDS];
  logic                    tag_we, data_we;

  logic [OFFW-1:0]         req_off;
  logic [IDXW-1:0]         req_idx;
  logic [TAGW-1:0]         req_tag;
  logic                    hit;
  logic                    lookup_hit;
  logic [DATA_WIDTH-1:0]   hit_word;
  logic                    unused_addr_bits;

  assign req_off  = addr_q[OFF-1:2];
  assign req_idx  = addr_q[OFF+IDXW-1:OFF];
  assign req_tag  = addr_q[ADDR_WIDTH-1:OFF+IDXW];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word = data_q[req_idx][req_off];
  assign unused_addr_bits = ^in_paddr[1:0];

  // Next-state logic for the fetch FSM, refill bookkeeping and valid bits.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    fence_pend_d = fence_pend_q;
    err_d        = err_q;
    over_d       = over_q;
    resp_d       = resp_q;
    valid_d      = valid_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fence_pend_q || fencei_i) begin
          valid_d      = '0;
          fence_pend_d = 1'b0;
        end
        if (in_psel) begin
          addr_d  = in_paddr[ADDR_WIDTH-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d = S_IDLE;
        end else begin
          // The victim line is invalidated up front since its data is about to be overwritten.
          valid_d[req_idx] = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          over_d  = 1'b0;
          state_d = S_MISS_AR;
        end
        if (fencei_i) valid_d = '0;
      end
      S_MISS_AR: begin
        if (fencei_i) fence_pend_d = 1'b1;
        if (axi_arready) state_d = S_MISS_R;
      end
      S_MISS_R: begin
        if (fencei_i) fence_pend_d = 1'b1;
        if (axi_rvalid) begin
          // Beats beyond the line length are dropped; over_q marks the burst as malformed.
          if (!over_q) begin
            data_we = 1'b1;
            if (cnt_q == req_off) resp_d = axi_rdata;
          end
          if (axi_rresp != 2'b00) err_d = 1'b1;
          if (cnt_q == LAST_BEAT) over_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (axi_rlast) begin
            tag_we = 1'b1;
            if (!over_q && (cnt_q == LAST_BEAT) && (axi_rresp == 2'b00) && !err_q
                && !fence_pend_q && !fencei_i)
              valid_d[req_idx] = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (fencei_i) fence_pend_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      fence_pend_q <= 1'b0;
      err_q        <= 1'b0;
      over_q       <= 1'b0;
      resp_q       <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      fence_pend_q <= fence_pend_d;
      err_q        <= err_d;
      over_q       <= over_d;
      resp_q       <= resp_d;
      valid_q      <= valid_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (data_we) data_q[req_idx][cnt_q] <= axi_rdata;
    if (tag_we)  tag_q[req_idx]         <= req_tag;
  end

  assign lookup_hit  = (state_q == S_LOOKUP) && hit;
  assign in_pready   = lookup_hit || (state_q == S_RESP);
  assign in_prdata   = lookup_hit ? hit_word : ((state_q == S_RESP) ? resp_q : '0);
  assign axi_arvalid = (state_q == S_MISS_AR);
  assign axi_araddr  = axi_arvalid ? {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}} : '0;
  assign axi_rready  = (state_q == S_MISS_R);
  assign axi_arlen   = 8'(LINE_WORDS - 1);
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;

`ifdef YSYX_23060025_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Self-checking bench for ysyx_23060025_icache: behavioural cache/memory model,
// AXI burst responder, per-cycle compare process and literal pins.
module tb_ysyx_23060025_icache;

  logic        clock;
  logic        reset;
  logic        in_psel;
  logic [31:0] in_paddr;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        fencei_i;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
`ifdef YSYX_23060025_ICACHE_PERF_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  ysyx_23060025_icache dut (
    .clock       (clock),
    .reset       (reset),
    .in_psel     (in_psel),
    .in_paddr    (in_paddr),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .fencei_i    (fencei_i),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast)
`ifdef YSYX_23060025_ICACHE_PERF_EN
    ,
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Backing memory: explicit words where the test needs them, a fixed pattern elsewhere.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Abstract cache model: one valid bit and one tag per set.
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  int          m_hits = 0;
  int          m_miss = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // Expectation of the fetch currently in flight.
  bit          chk_en = 1'b0;
  bit          busy = 1'b0;
  bit          ehit = 1'b0;
  int          ew = 0;
  int          s_cyc = 0;
  logic [31:0] edata = '0;
  logic [31:0] eline = '0;
  logic [31:0] last_data = '0;
  int          ar_cnt = 0;
  int          rel;
  bit          e_pr, e_ar, e_rr;

  // Compare process: latency rules are hit=1 cycle, miss=3+arwait+4 beats.
  always @(negedge clock) begin
    if (chk_en && reset) begin
      rel  = cyc - s_cyc;
      e_pr = busy && (ehit ? (rel == 1) : (rel == 7 + ew));
      e_ar = busy && !ehit && (rel >= 2) && (rel <= 2 + ew);
      e_rr = busy && !ehit && (rel >= 3 + ew) && (rel <= 6 + ew);
      chk("pready", 32'(in_pready), 32'(e_pr));
      chk("arvalid", 32'(axi_arvalid), 32'(e_ar));
      chk("rready", 32'(axi_rready), 32'(e_rr));
      if (e_pr) chk("prdata", in_prdata, edata);
      if (e_ar) chk("araddr", axi_araddr, eline);
      if (in_pready) last_data = in_prdata;
      if (axi_arvalid && axi_arready) ar_cnt++;
    end
  end

  // AXI read responder: optional AR wait, then LINE_WORDS contiguous beats.
  int          cfg_w = 0;
  int          cfg_err = -1;
  bit          bursting;
  int          beat;
  int          wait_left;
  logic [31:0] rbase;
  bit          r_hs = 1'b0;

  always @(negedge clock) r_hs = axi_rvalid && axi_rready;

  task automatic present_beat();
    axi_rvalid = 1'b1;
    axi_rdata  = mem_rd(rbase + 32'(4 * beat));
    axi_rresp  = (beat == cfg_err) ? 2'b10 : 2'b00;
    axi_rlast  = (beat == 3);
  endtask

  initial begin
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
    bursting = 1'b0; beat = 0; wait_left = 0; rbase = '0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
        bursting = 1'b0; beat = 0;
      end else begin
        #1;
        if (axi_arready) begin
          axi_arready = 1'b0;
          bursting = 1'b1;
          beat = 0;
          present_beat();
        end else if (bursting) begin
          if (r_hs) begin
            beat++;
            if (beat == 4) begin
              bursting = 1'b0;
              axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
            end else present_beat();
          end
        end else if (axi_arvalid) begin
          if (wait_left > 0) wait_left--;
          else begin
            axi_arready = 1'b1;
            rbase = axi_araddr;
          end
        end else wait_left = cfg_w;
      end
    end
  end

  // One IFU fetch; expectations come from the model, literals pin the observed result.
  task automatic applyStimulus(input logic [31:0] a, input int w, input int fence_at,
                               input int err_beat, input int lit_miss,
                               input logic [31:0] lit_data);
    int          idx;
    logic [23:0] tg;
    bit          hit;
    int          lat;
    int          ar0;
    idx = int'(a[7:4]);
    tg  = a[31:8];
    hit = mvalid[idx] && (mtag[idx] == tg);
    lat = hit ? 1 : 7 + w;
    @(posedge clock); #1;
    cfg_w = w; cfg_err = err_beat;
    ehit = hit; ew = w; edata = mem_rd(a); eline = {a[31:4], 4'h0};
    s_cyc = cyc; busy = 1'b1; ar0 = ar_cnt; last_data = 32'hDEAD_BEEF;
    in_psel = 1'b1; in_paddr = a;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clock); #1;
      fencei_i = (i == fence_at);
    end
    in_psel = 1'b0;
    @(posedge clock); #1;
    fencei_i = 1'b0;
    busy = 1'b0;
    if (hit) m_hits++; else m_miss++;
    if (fence_at == 1) model_clear();
    if (!hit) begin
      mtag[idx]   = tg;
      mvalid[idx] = (err_beat < 0) && (fence_at < 2);
    end
    if (fence_at >= 2) model_clear();
    if (lit_miss >= 0) begin
      chk("ar_count", 32'(ar_cnt - ar0), 32'(lit_miss));
      chk("fetch_data", last_data, lit_data);
    end
  endtask

  task automatic fence_pulse();
    @(posedge clock); #1 fencei_i = 1'b1;
    @(posedge clock); #1 fencei_i = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b0; in_psel = 1'b0; in_paddr = '0; fencei_i = 1'b0;
    mem[32'h3000_0000] = 32'h11;
    mem[32'h3000_0004] = 32'h22;
    mem[32'h3000_0008] = 32'h33;
    mem[32'h3000_000C] = 32'h44;
    model_clear();

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_pready", 32'(in_pready), 32'd0);
    chk("rst_prdata", in_prdata, 32'd0);
    chk("rst_arvalid", 32'(axi_arvalid), 32'd0);
    chk("rst_araddr", axi_araddr, 32'd0);
    chk("rst_rready", 32'(axi_rready), 32'd0);
    chk("rst_arlen", 32'(axi_arlen), 32'd3);
    chk("rst_arsize", 32'(axi_arsize), 32'd2);
    chk("rst_arburst", 32'(axi_arburst), 32'd1);
    @(posedge clock); #1 reset = 1'b1;
    chk_en = 1'b1;

    applyStimulus(32'h3000_0004, 0, 0, -1, 1, 32'h22);
    applyStimulus(32'h3000_0008, 0, 0, -1, 0, 32'h33);
    applyStimulus(32'h3000_0100, 0, 0, -1, 1, 32'h6A5A_0100);
    applyStimulus(32'h3000_0000, 0, 0, -1, 1, 32'h11);
    applyStimulus(32'h3000_0010, 2, 0, -1, 1, 32'h6A5A_0010);
    applyStimulus(32'h3000_0014, 0, 0, -1, 0, 32'h6A5A_0014);

    applyStimulus(32'h3000_0020, 0, 4, -1, 1, 32'h6A5A_0020);
    applyStimulus(32'h3000_0020, 0, 0, -1, 1, 32'h6A5A_0020);
    applyStimulus(32'h3000_0000, 0, 0, -1, 1, 32'h11);
    applyStimulus(32'h3000_0010, 0, 0, -1, 1, 32'h6A5A_0010);

    applyStimulus(32'h3000_0024, 0, 0, -1, 0, 32'h6A5A_0024);
    fence_pulse();
    applyStimulus(32'h3000_0024, 0, 0, -1, 1, 32'h6A5A_0024);
    applyStimulus(32'h3000_0028, 0, 1, -1, 0, 32'h6A5A_0028);
    applyStimulus(32'h3000_0028, 0, 0, -1, 1, 32'h6A5A_0028);
    applyStimulus(32'h3000_0050, 1, 7, -1, 1, 32'h6A5A_0050);
    applyStimulus(32'h3000_0050, 0, 0, -1, 1, 32'h6A5A_0050);

    applyStimulus(32'h3000_0044, 0, 0, 1, 1, 32'h6A5A_0044);
    applyStimulus(32'h3000_0044, 0, 0, -1, 1, 32'h6A5A_0044);
    applyStimulus(32'h3000_0048, 0, 0, -1, 0, 32'h6A5A_0048);

    // Asynchronous reset while the refill burst is in progress.
    @(posedge clock); #1;
    cfg_w = 0; cfg_err = -1; chk_en = 1'b0;
    in_psel = 1'b1; in_paddr = 32'h3000_0030;
    repeat (4) @(posedge clock);
    #1 in_psel = 1'b0;
    chk("mid_rready", 32'(axi_rready), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_arvalid", 32'(axi_arvalid), 32'd0);
    chk("rst_mid_rready", 32'(axi_rready), 32'd0);
    chk("rst_mid_pready", 32'(in_pready), 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    model_clear();
    m_hits = 0; m_miss = 0;
    @(posedge clock); #1 chk_en = 1'b1;

    applyStimulus(32'h3000_0004, 0, 0, -1, 1, 32'h22);
    applyStimulus(32'h3000_0004, 0, 0, -1, 0, 32'h22);
    applyStimulus(32'h3000_0008, 0, 0, -1, 0, 32'h33);
    applyStimulus(32'h3000_0080, 0, 0, -1, 1, 32'h6A5A_0080);
    applyStimulus(32'h3000_0084, 0, 0, -1, 0, 32'h6A5A_0084);

`ifdef YSYX_23060025_ICACHE_PERF_EN
    chk("perf_hit", perf_hit_cnt, 32'd3);
    chk("perf_miss", perf_miss_cnt, 32'd2);
    chk("perf_hit_model", perf_hit_cnt, 32'(m_hits));
    chk("perf_miss_model", perf_miss_cnt, 32'(m_miss));
`endif

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
